// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, sizes and leading-zero mask for the display scan controller
package seg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;

  // Bit i set when nibbles NUM_DIGITS-1..i are all zero; digit 0 is never masked.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS*NIBBLE_W-1:0] word);
    logic [NUM_DIGITS-1:0] m;
    logic                  all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (word[i*NIBBLE_W +: NIBBLE_W] == '0);
      if (i != 0) m[i] = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - per-state cycle counter with terminal-count flag for the scan FSM
module scan_timer #(
  parameter int BLANK_CYC = 2,
  parameter int SHOW_CYC  = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic show,
  output logic tc
);

  localparam int MAX_CYC = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;

  assign last = show ? CW'(SHOW_CYC - 1) : CW'(BLANK_CYC - 1);
  assign tc   = (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr || tc)  cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit seven-segment scan controller with blanking gap and frame-aligned loads
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int BLANK_CYC = 2,
  parameter int SHOW_CYC  = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lz_en,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic [1:0]  m4out,
  output logic [15:0] out,
  output logic [3:0]  an,
  output logic        applied
);

  state_t      state, state_n;
  logic [1:0]  digit, digit_n;
  logic [15:0] shadow;
  logic        pending;
  logic        tc;
  logic        frame_end;
  logic        take_now;
  logic [3:0]  sup;
  logic [3:0]  an_n;

  scan_timer #(
    .BLANK_CYC (BLANK_CYC),
    .SHOW_CYC  (SHOW_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!en),
    .show  (state == SHOW),
    .tc    (tc)
  );

  assign frame_end = en && tc && (state == SHOW) && (digit == 2'd3);
  // Out may only change at a frame boundary, or immediately while the scan is stopped.
  assign take_now  = frame_end || !en;
  assign m4out     = digit;

  always_comb begin
    state_n = state;
    digit_n = digit;
    if (!en) begin
      state_n = BLANK;
      digit_n = 2'd0;
    end else if (tc) begin
      state_n = (state == BLANK) ? SHOW : BLANK;
      if (state == SHOW) digit_n = digit + 2'd1;
    end
  end

  // Anodes are registered from next-state so they track the state register without lag.
  always_comb begin
    sup  = lz_en ? lz_mask(out) : 4'b0000;
    an_n = 4'b1111;
    if (en && (state_n == SHOW) && !sup[digit_n])
      an_n = ~(4'b0001 << digit_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BLANK;
      digit   <= 2'd0;
      an      <= 4'b1111;
      out     <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
      applied <= 1'b0;
    end else begin
      state   <= state_n;
      digit   <= digit_n;
      an      <= an_n;
      applied <= 1'b0;
      if (take_now && load) begin
        out     <= value_in;
        pending <= 1'b0;
        applied <= 1'b1;
      end else if (take_now && pending) begin
        out     <= shadow;
        pending <= 1'b0;
        applied <= 1'b1;
      end else if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        lz_en;
  logic        load;
  logic [15:0] value_in;
  logic [1:0]  m4out;
  logic [15:0] out;
  logic [3:0]  an;
  logic        applied;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  seg_scan_ctrl #(
    .BLANK_CYC (2),
    .SHOW_CYC  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .lz_en    (lz_en),
    .load     (load),
    .value_in (value_in),
    .m4out    (m4out),
    .out      (out),
    .an       (an),
    .applied  (applied)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // k counts clocks since the scan (re)started at BLANK, digit 0: 2 blank + 4 show per digit.
  function automatic logic [3:0] exp_an(input int kk, input logic [15:0] w, input logic lz);
    int ph;
    int d;
    ph = kk % 6;
    d  = (kk / 6) % 4;
    if (ph < 2) return 4'hf;
    if (lz && d > 0 && (w >> (4 * d)) == 16'h0000) return 4'hf;
    return ~(4'h1 << d);
  endfunction

  function automatic logic [15:0] exp_word(input int kk);
    if (kk < 24) return 16'h0000;
    if (kk < 48) return 16'h1234;
    if (kk < 72) return 16'h5555;
    return 16'hBEEF;
  endfunction

  task automatic chk_cycle(input logic [15:0] eo, input logic ea);
    chk($sformatf("an k=%0d", k), 32'(an), 32'(exp_an(k, eo, lz_en)));
    chk($sformatf("m4out k=%0d", k), 32'(m4out), 32'((k / 6) % 4));
    chk($sformatf("out k=%0d", k), 32'(out), 32'(eo));
    chk($sformatf("applied k=%0d", k), 32'(applied), 32'(ea));
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    lz_en    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset an", 32'(an), 32'h000f);
    chk("reset m4out", 32'(m4out), 32'h0);
    chk("reset out", 32'(out), 32'h0);
    chk("reset applied", 32'(applied), 32'h0);
    rst_n = 1'b1;
    k     = 0;

    // Four frames: mid-frame load, last-load-wins, frame-end bypass over a pending word.
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk_cycle(exp_word(k), (k == 24) || (k == 48) || (k == 72));
      load = 1'b0;
      case (k)
        8:  begin load = 1'b1; value_in = 16'h1234; end
        30: begin load = 1'b1; value_in = 16'hAAAA; end
        40: begin load = 1'b1; value_in = 16'h5555; end
        55: begin load = 1'b1; value_in = 16'h1111; end
        71: begin load = 1'b1; value_in = 16'hBEEF; end
        99: begin load = 1'b1; value_in = 16'h0000; end
        default: ;
      endcase
    end

    // Drop en mid-SHOW with 0000 pending: blank next cycle and apply at once.
    en = 1'b0;
    tick();
    chk("en0 an", 32'(an), 32'h000f);
    chk("en0 m4out", 32'(m4out), 32'h0);
    chk("en0 out", 32'(out), 32'h0000);
    chk("en0 applied", 32'(applied), 32'h1);
    load     = 1'b1;
    value_in = 16'h0070;
    tick();
    chk("en0 bypass out", 32'(out), 32'h0070);
    chk("en0 bypass applied", 32'(applied), 32'h1);
    load = 1'b0;
    tick();
    chk("en0 idle applied", 32'(applied), 32'h0);
    chk("en0 idle an", 32'(an), 32'h000f);

    // Restart with leading-zero suppression on 0070.
    lz_en = 1'b1;
    en    = 1'b1;
    k     = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk_cycle(16'h0070, 1'b0);
    end

    en       = 1'b0;
    load     = 1'b1;
    value_in = 16'h0000;
    tick();
    chk("bypass0 out", 32'(out), 32'h0000);
    chk("bypass0 applied", 32'(applied), 32'h1);
    load = 1'b0;
    en   = 1'b1;
    k    = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      chk_cycle(16'h0000, 1'b0);
    end

    // Mid-frame reset with a word pending: pending must be discarded.
    lz_en = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_cycle(16'h0000, 1'b0);
      load = (k == 30);
      value_in = 16'h1234;
    end
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst an", 32'(an), 32'h000f);
    chk("midrst m4out", 32'(m4out), 32'h0);
    chk("midrst out", 32'(out), 32'h0);
    chk("midrst applied", 32'(applied), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k     = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk_cycle(16'h0000, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
